// File: rtl/o_buf_pkg.sv
// Shared constants for the ping-pong output buffer.
//   MODE_WS / MODE_OS : capture mode encodings (mode input).
//   ST_*              : capture FSM state encoding.
//   FLUSH_CYCLES      : cycles spent draining the read-modify-write pipe.
//   min_int           : small clamp helper used when latching the tile shape.
package o_buf_pkg;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int FLUSH_CYCLES = 2;

    function automatic int min_int(input int a, input int b);
        return (a > b) ? b : a;
    endfunction

endpackage

// File: rtl/o_buffer_pingpong_acc_if.sv
// Bus bundle of the ping-pong output buffer.
//   Tile control : start, mode, accum_en, num_cols, num_rows, base_addr -> busy, done, wr_bank
//   Capture beat : in_valid, data_set_in (column c at [c*OUT_WIDTH +: OUT_WIDTH])
//   Host read    : rd_en, ram_idx, read_addr -> data_read, rd_valid (1-cycle latency)
// master = host / array side, slave = buffer.
interface o_buffer_pingpong_acc_if #(
    parameter int ARRAY_M    = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8
);
    localparam int COLS_W = $clog2(ARRAY_M) + 1;
    localparam int IDX_W  = $clog2(ARRAY_M);

    logic                          start;
    logic                          mode;
    logic                          accum_en;
    logic [COLS_W-1:0]             num_cols;
    logic [ADDR_WIDTH-1:0]         num_rows;
    logic [ADDR_WIDTH-1:0]         base_addr;
    logic                          in_valid;
    logic [ARRAY_M*OUT_WIDTH-1:0]  data_set_in;
    logic                          busy;
    logic                          done;
    logic                          wr_bank;
    logic                          rd_en;
    logic [IDX_W-1:0]              ram_idx;
    logic [ADDR_WIDTH-1:0]         read_addr;
    logic [OUT_WIDTH-1:0]          data_read;
    logic                          rd_valid;

    modport master (
        output start, mode, accum_en, num_cols, num_rows, base_addr,
        output in_valid, data_set_in, rd_en, ram_idx, read_addr,
        input  busy, done, wr_bank, data_read, rd_valid
    );

    modport slave (
        input  start, mode, accum_en, num_cols, num_rows, base_addr,
        input  in_valid, data_set_in, rd_en, ram_idx, read_addr,
        output busy, done, wr_bank, data_read, rd_valid
    );

endinterface

// File: rtl/o_buf_col_ram.sv
// One column RAM of one bank: a single write port plus two independent
// registered read ports (rmw_* for the accumulate pipe, host_* for host reads).
//   clk, reset            : clock, async active-high reset (clears read registers only)
//   we, waddr, wdata      : write port
//   rmw_re, rmw_addr      : read-modify-write read request, data on rmw_q next cycle
//   host_re, host_addr    : host read request, data on host_q next cycle
// Read registers hold their value while their enable is low.
module o_buf_col_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rmw_re,
    input  logic [AW-1:0]    rmw_addr,
    output logic [WIDTH-1:0] rmw_q,
    input  logic             host_re,
    input  logic [AW-1:0]    host_addr,
    output logic [WIDTH-1:0] host_q
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rmw_q  <= '0;
            host_q <= '0;
        end else begin
            if (rmw_re) begin
                rmw_q <= mem_r[rmw_addr];
            end
            if (host_re) begin
                host_q <= mem_r[host_addr];
            end
        end
    end

endmodule

// File: rtl/o_buffer_pingpong_acc.sv
// Ping-pong output buffer behind the ARRAY_M-column systolic array.
// Captures one tile into the write bank (WS: column c skewed by c beats,
// OS: aligned rows), optionally accumulating onto the stored words, while the
// host reads the other bank. The banks swap on the done pulse.
//   clk, reset : clock, async active-high reset
//   bus        : o_buffer_pingpong_acc_if.slave (tile control, capture beats, host read)
// Write path is two stages per column: stage0 reads the old word, stage1
// writes old+new (or new). Both stages stall together with in_valid.
module o_buffer_pingpong_acc
    import o_buf_pkg::*;
#(
    parameter int RAM_SIZE   = 256,
    parameter int ARRAY_M    = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    o_buffer_pingpong_acc_if.slave    bus
);

    localparam int COLS_W = $clog2(ARRAY_M) + 1;
    localparam int IDX_W  = $clog2(ARRAY_M);

    logic [1:0]            state_r;
    logic [CNT_WIDTH-1:0]  beat_r;
    logic [CNT_WIDTH-1:0]  total_r;
    logic [1:0]            flush_cnt_r;
    logic                  mode_r;
    logic                  accum_r;
    logic [COLS_W-1:0]     cols_r;
    logic [ADDR_WIDTH-1:0] rows_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  wr_bank_r;

    logic [COLS_W-1:0]     cols_clamp_s;
    logic                  tile_empty_s;
    logic                  issue_s;
    logic                  advance_s;
    logic                  last_beat_s;

    logic [ARRAY_M-1:0]    in_win_s;
    logic [CNT_WIDTH-1:0]  off_s     [ARRAY_M];
    logic [ARRAY_M-1:0]    s0_we_s;
    logic [ADDR_WIDTH-1:0] s0_addr_s [ARRAY_M];

    logic [ARRAY_M-1:0]    s1_we_r;
    logic [ADDR_WIDTH-1:0] s1_addr_r [ARRAY_M];
    logic [OUT_WIDTH-1:0]  s1_data_r [ARRAY_M];

    logic [ARRAY_M-1:0]    wr_s;
    logic [OUT_WIDTH-1:0]  wdata_s   [ARRAY_M];
    logic [OUT_WIDTH-1:0]  rmw_q_s   [2][ARRAY_M];
    logic [OUT_WIDTH-1:0]  host_q_s  [2][ARRAY_M];

    logic                  rd_bank_r;
    logic [IDX_W-1:0]      rd_idx_r;
    logic                  rd_valid_r;

    // Tile shape decode at start and pipeline advance qualifiers.
    always_comb begin
        cols_clamp_s = COLS_W'(min_int(int'(bus.num_cols), ARRAY_M));
        tile_empty_s = (bus.num_cols == '0) || (bus.num_rows == '0);
        issue_s      = (state_r == ST_CAPTURE) && bus.in_valid;
        advance_s    = issue_s || (state_r == ST_FLUSH);
        last_beat_s  = issue_s && (beat_r == total_r - CNT_WIDTH'(1));
    end

    // Stage0: per-column write mask and address for the current beat.
    always_comb begin
        for (int c = 0; c < ARRAY_M; c++) begin
            if (mode_r == MODE_OS) begin
                in_win_s[c] = 1'b1;
                off_s[c]    = beat_r;
            end else begin
                // Column c sees row r at beat r+c; outside that window it is masked.
                in_win_s[c] = (beat_r >= CNT_WIDTH'(c)) &&
                              (beat_r <  CNT_WIDTH'(c) + CNT_WIDTH'(rows_r));
                off_s[c]    = beat_r - CNT_WIDTH'(c);
            end
            s0_we_s[c]   = issue_s && in_win_s[c] && (CNT_WIDTH'(c) < CNT_WIDTH'(cols_r));
            s0_addr_s[c] = base_r + ADDR_WIDTH'(off_s[c]);
        end
    end

    // Stage1 registers: hold while stalled, otherwise take the stage0 beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_we_r <= '0;
            for (int c = 0; c < ARRAY_M; c++) begin
                s1_addr_r[c] <= '0;
                s1_data_r[c] <= '0;
            end
        end else if (advance_s) begin
            s1_we_r <= s0_we_s;
            for (int c = 0; c < ARRAY_M; c++) begin
                s1_addr_r[c] <= s0_addr_s[c];
                s1_data_r[c] <= bus.data_set_in[c*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Stage1 write data: accumulate onto the word read in stage0, or overwrite.
    always_comb begin
        for (int c = 0; c < ARRAY_M; c++) begin
            wr_s[c]    = s1_we_r[c] && advance_s;
            wdata_s[c] = accum_r ? (rmw_q_s[wr_bank_r][c] + s1_data_r[c]) : s1_data_r[c];
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar c = 0; c < ARRAY_M; c++) begin : g_col
            o_buf_col_ram #(
                .DEPTH (RAM_SIZE),
                .WIDTH (OUT_WIDTH),
                .AW    (ADDR_WIDTH)
            ) u_ram (
                .clk       (clk),
                .reset     (reset),
                .we        (wr_s[c] && (wr_bank_r == 1'(b))),
                .waddr     (s1_addr_r[c]),
                .wdata     (wdata_s[c]),
                .rmw_re    (s0_we_s[c] && (wr_bank_r == 1'(b))),
                .rmw_addr  (s0_addr_s[c]),
                .rmw_q     (rmw_q_s[b][c]),
                .host_re   (bus.rd_en && (wr_bank_r != 1'(b)) && (bus.ram_idx == IDX_W'(c))),
                .host_addr (bus.read_addr),
                .host_q    (host_q_s[b][c])
            );
        end
    end

    // Tile FSM: latch shape at start, count beats, drain, pulse done and swap banks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            beat_r      <= '0;
            total_r     <= '0;
            flush_cnt_r <= 2'd0;
            mode_r      <= MODE_WS;
            accum_r     <= 1'b0;
            cols_r      <= '0;
            rows_r      <= '0;
            base_r      <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wr_bank_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_r      <= bus.mode;
                        accum_r     <= bus.accum_en;
                        cols_r      <= cols_clamp_s;
                        rows_r      <= bus.num_rows;
                        base_r      <= bus.base_addr;
                        total_r     <= (bus.mode == MODE_OS) ? CNT_WIDTH'(bus.num_rows) :
                                       CNT_WIDTH'(bus.num_rows) + CNT_WIDTH'(cols_clamp_s) - CNT_WIDTH'(1);
                        beat_r      <= '0;
                        flush_cnt_r <= 2'd0;
                        busy_r      <= 1'b1;
                        state_r     <= tile_empty_s ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.in_valid) begin
                        if (last_beat_s) begin
                            state_r <= ST_FLUSH;
                        end else begin
                            beat_r <= beat_r + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r == 2'(FLUSH_CYCLES - 1)) begin
                        state_r <= ST_DONE;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + 2'd1;
                    end
                end
                ST_DONE: begin
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    wr_bank_r <= ~wr_bank_r;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Host read bookkeeping: the read bank is sampled together with rd_en,
    // so a read on the swap edge still targets the pre-swap read bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_bank_r  <= 1'b0;
            rd_idx_r   <= '0;
        end else begin
            rd_valid_r <= bus.rd_en;
            if (bus.rd_en) begin
                rd_bank_r <= ~wr_bank_r;
                rd_idx_r  <= bus.ram_idx;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.wr_bank   = wr_bank_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.data_read = host_q_s[rd_bank_r][rd_idx_r];

endmodule
